// File: rtl/fifo_block_assembler_pkg.sv
// Shared definitions for the FIFO-to-AES block assembler and the FIFO read port.
package fifo_block_assembler_pkg;

  localparam int AES_BLK_W  = 128;
  localparam int AES_WORD_W = 32;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } asm_state_e;

  // Ceiling log2, also used by the FIFO for its pointer widths.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fifo_rd_port.sv
// Generic FIFO read-side requester: issues up to WORDS reads per batch and
// flags the cycle in which each granted word appears on rdata.
module fifo_rd_port
  import fifo_block_assembler_pkg::*;
#(
  parameter int WORDS = 4,
  parameter int CW    = clog2(WORDS) + 1
) (
  input  logic clk,
  input  logic arst_n,
  input  logic clr,
  input  logic rempty,
  input  logic enable,
  input  logic restart,
  output logic rrq,
  output logic pend
);

  logic [CW-1:0] issued;
  logic          grant;

  // rrq is held low in reset so a non-empty FIFO is never popped then.
  assign rrq   = arst_n & enable & ~rempty & (issued < CW'(WORDS)) & ~clr;
  assign grant = rrq & ~rempty;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      pend   <= 1'b0;
      issued <= '0;
    end else if (clr) begin
      pend   <= 1'b0;
      issued <= '0;
    end else begin
      pend <= grant;
      if (restart) begin
        issued <= '0;
      end else if (grant) begin
        issued <= issued + 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_block_assembler.sv
// Packs WORDS consecutive FIFO words (first word in the MSBs) into one AES
// block and offers it on a valid/ready output.
module fifo_block_assembler
  import fifo_block_assembler_pkg::*;
#(
  parameter int DWIDTH = AES_WORD_W,
  parameter int BWIDTH = AES_BLK_W
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              clr,
  input  logic              rempty,
  input  logic [DWIDTH-1:0] rdata,
  output logic              rrq,
  output logic [BWIDTH-1:0] blk_data,
  output logic              blk_valid,
  input  logic              blk_ready,
  output logic [15:0]       blk_cnt,
  output asm_state_e        dbg_state
);

  // BWIDTH must be a whole multiple of DWIDTH.
  localparam int WORDS = BWIDTH / DWIDTH;
  localparam int CW    = clog2(WORDS) + 1;

  // Handshake: a block transfers on any edge where blk_valid & blk_ready;
  // blk_data is frozen while blk_valid is high and blk_ready alone does nothing.
  asm_state_e    state;
  logic [CW-1:0] captured;
  logic          pend;
  logic          restart;

  assign restart   = (state == HOLD) & blk_ready & ~clr;
  assign dbg_state = state;

  fifo_rd_port #(
    .WORDS (WORDS),
    .CW    (CW)
  ) u_rd_port (
    .clk     (clk),
    .arst_n  (arst_n),
    .clr     (clr),
    .rempty  (rempty),
    .enable  (state == FILL),
    .restart (restart),
    .rrq     (rrq),
    .pend    (pend)
  );

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state     <= FILL;
      captured  <= '0;
      blk_data  <= '0;
      blk_valid <= 1'b0;
      blk_cnt   <= '0;
    end else if (clr) begin
      // A word landing this edge belongs to the dropped block and is ignored.
      state     <= FILL;
      captured  <= '0;
      blk_valid <= 1'b0;
    end else begin
      case (state)
        FILL: begin
          if (pend) begin
            blk_data <= {blk_data[BWIDTH-DWIDTH-1:0], rdata};
            captured <= captured + 1'b1;
            if (captured == CW'(WORDS - 1)) begin
              state     <= HOLD;
              blk_valid <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (blk_ready) begin
            state     <= FILL;
            captured  <= '0;
            blk_valid <= 1'b0;
            blk_cnt   <= blk_cnt + 16'd1;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule
